// File: rtl/conv1_event_gen_pkg.sv
// rtl/conv1_event_gen_pkg.sv - conv1 event word layout, FSM states and entry packing
package conv1_event_gen_pkg;

  localparam int CONV1_CHANNEL_I_WIDE = 8;
  localparam int CONV1_CHANNEL_O_WIDE = 7;
  localparam int CONV1_PX_X_WIDE_     = 2;
  localparam int CONV1_PX_Y_WIDE_     = 2;
  localparam int RELATIVE_POS         = 2;
  localparam int ENTRY_W              = 23;

  localparam int PIX_Y_LSB = 0;
  localparam int PIX_X_LSB = 2;
  localparam int CO_LSB    = 4;
  localparam int TAP_Y_LSB = 11;
  localparam int TAP_X_LSB = 13;
  localparam int CI_LSB    = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_EMIT,
    ST_NEXT,
    ST_DONE
  } state_t;

  // Pixel index p = {py,px}; coordinates are 1-based so they land in {1,2}.
  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [CONV1_CHANNEL_I_WIDE-1:0] ci,
    input logic [CONV1_CHANNEL_O_WIDE-1:0] co,
    input logic [1:0]                      pix,
    input logic [1:0]                      tap
  );
    logic [CONV1_PX_X_WIDE_-1:0] pix_x;
    logic [CONV1_PX_Y_WIDE_-1:0] pix_y;
    logic [RELATIVE_POS-1:0]     tap_x;
    logic [RELATIVE_POS-1:0]     tap_y;
    pix_x = {1'b0, pix[0]} + 2'd1;
    pix_y = {1'b0, pix[1]} + 2'd1;
    tap_x = {1'b0, tap[0]};
    tap_y = {1'b0, tap[1]};
    pack_entry = {ci, tap_x, tap_y, co, pix_x, pix_y};
  endfunction

endpackage

// File: rtl/conv1_mask_pri_enc.sv
// rtl/conv1_mask_pri_enc.sv - lowest-set-bit encoder for a 4-bit spike mask
module conv1_mask_pri_enc (
  input  logic [3:0] mask,
  output logic [1:0] idx,
  output logic       any
);

  always_comb begin
    any = |mask;
    if (mask[0])      idx = 2'd0;
    else if (mask[1]) idx = 2'd1;
    else if (mask[2]) idx = 2'd2;
    else              idx = 2'd3;
  end

endmodule

// File: rtl/conv1_event_gen.sv
// rtl/conv1_event_gen.sv - scans spike masks per timestep and writes conv1 event FIFO entries
module conv1_event_gen
  import conv1_event_gen_pkg::*;
#(
  parameter int CONV1_CHANNEL_NUM_O = 128,
  parameter int CONV1_CHANNEL_NUM_I = 256,
  parameter int SPIKE_RAM_LAT       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  addr_r_spike,
  input  logic [3:0]  spike_mask,
  input  logic        full,
  output logic        w_en,
  output logic [22:0] valid_pix_pos_o
);

  localparam logic [6:0] CO_LAST   = 7'(CONV1_CHANNEL_NUM_O - 1);
  localparam logic [7:0] CI_LAST   = 8'(CONV1_CHANNEL_NUM_I - 1);
  localparam logic [1:0] WAIT_LAST = 2'(SPIKE_RAM_LAT - 1);

  state_t      state;
  logic [6:0]  co;
  logic [7:0]  ci;
  logic [3:0]  mask_reg;
  logic [1:0]  pix;
  logic [1:0]  tap;
  logic [1:0]  wait_cnt;
  logic [22:0] word_q;

  logic [3:0]  mask_clr;
  logic [3:0]  enc_in;
  logic [1:0]  enc_idx;
  logic        enc_any;

  // One encoder serves both the fresh RAM word and the mask after retiring a pixel.
  assign mask_clr = mask_reg & ~(4'b0001 << pix);
  assign enc_in   = (state == ST_WAIT) ? spike_mask : mask_clr;

  conv1_mask_pri_enc u_enc (
    .mask (enc_in),
    .idx  (enc_idx),
    .any  (enc_any)
  );

  assign w_en            = (state == ST_EMIT) && !full;
  assign valid_pix_pos_o = word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      addr_r_spike <= '0;
      co           <= '0;
      ci           <= '0;
      mask_reg     <= '0;
      pix          <= '0;
      tap          <= '0;
      wait_cnt     <= '0;
      word_q       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy         <= 1'b1;
            co           <= '0;
            ci           <= '0;
            addr_r_spike <= '0;
            state        <= ST_RD;
          end
        end
        ST_RD: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            mask_reg <= spike_mask;
            if (enc_any) begin
              pix    <= enc_idx;
              tap    <= 2'd0;
              word_q <= pack_entry(ci, co, enc_idx, 2'd0);
              state  <= ST_EMIT;
            end else begin
              state <= ST_NEXT;
            end
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        ST_EMIT: begin
          if (!full) begin
            if (tap != 2'd3) begin
              tap    <= tap + 2'd1;
              word_q <= pack_entry(ci, co, pix, tap + 2'd1);
            end else begin
              mask_reg <= mask_clr;
              tap      <= 2'd0;
              if (enc_any) begin
                pix    <= enc_idx;
                word_q <= pack_entry(ci, co, enc_idx, 2'd0);
              end else begin
                state <= ST_NEXT;
              end
            end
          end
        end
        ST_NEXT: begin
          if (ci < CI_LAST) begin
            ci           <= ci + 8'd1;
            addr_r_spike <= ci + 8'd1;
            state        <= ST_RD;
          end else if (co < CO_LAST) begin
            ci           <= '0;
            addr_r_spike <= '0;
            co           <= co + 7'd1;
            state        <= ST_RD;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1_event_gen.sv
// tb/tb_conv1_event_gen.sv - directed bench with an entry-sequence model for conv1_event_gen
module tb_conv1_event_gen;

  localparam int NUM_O = 2;
  localparam int NUM_I = 2;
  localparam int LAT   = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  addr_r_spike;
  logic [3:0]  spike_mask;
  logic        full;
  logic        w_en;
  logic [22:0] valid_pix_pos_o;

  logic [3:0]  mem [0:NUM_I-1];
  logic [22:0] exp_q [$];
  logic [22:0] got_q [$];
  int          errors = 0;
  int          checks = 0;
  int          n_wr = 0;
  int          done_cnt;
  int          busy_cnt;

  conv1_event_gen #(
    .CONV1_CHANNEL_NUM_O (NUM_O),
    .CONV1_CHANNEL_NUM_I (NUM_I),
    .SPIKE_RAM_LAT       (LAT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .addr_r_spike    (addr_r_spike),
    .spike_mask      (spike_mask),
    .full            (full),
    .w_en            (w_en),
    .valid_pix_pos_o (valid_pix_pos_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) spike_mask <= mem[addr_r_spike[0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] model_word(input int ci, input int co, input int p, input int t);
    return 23'(ci * 32768 + (t % 2) * 8192 + (t / 2) * 2048 + co * 16
               + ((p % 2) + 1) * 4 + ((p / 2) + 1));
  endfunction

  function automatic logic [22:0] got_at(input int i);
    return (got_q.size() > i) ? got_q[i] : 23'h7fffff;
  endfunction

  task automatic begin_test();
    exp_q.delete();
    got_q.delete();
    n_wr = 0;
    for (int co = 0; co < NUM_O; co++)
      for (int ci = 0; ci < NUM_I; ci++)
        for (int p = 0; p < 4; p++)
          if (mem[ci][p])
            for (int t = 0; t < 4; t++) exp_q.push_back(model_word(ci, co, p, t));
  endtask

  task automatic start_pulse();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_window(input int cycles);
    done_cnt = 0;
    busy_cnt = 0;
    repeat (cycles) begin
      @(negedge clk); #1;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic wait_wr(input int n);
    int k = 0;
    while (n_wr < n && k < 100) begin
      @(negedge clk); #2;
      k++;
    end
    chk("wait_wr_bound", 32'(n_wr >= n), 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (full) chk("w_en_while_full", 32'(w_en), 32'd0);
      if (w_en) begin
        got_q.push_back(valid_pix_pos_o);
        n_wr++;
        if (exp_q.size() == 0) chk("extra_entry", 32'(valid_pix_pos_o), 32'h7fffffff);
        else chk("entry_seq", 32'(valid_pix_pos_o), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; full = 1'b0;
    mem[0] = 4'b0000; mem[1] = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_w_en", 32'(w_en), 32'd0);
    chk("rst_addr", 32'(addr_r_spike), 32'd0);
    chk("rst_word", 32'(valid_pix_pos_o), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // all masks empty
    begin_test();
    start_pulse();
    run_window(40);
    chk("t1_busy_cycles", 32'(busy_cnt), 32'd12);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_entries", 32'(n_wr), 32'd0);

    // one pixel on channel_i 1
    mem[0] = 4'b0000; mem[1] = 4'b0001;
    begin_test();
    start_pulse();
    run_window(60);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);
    chk("t2_entries", 32'(n_wr), 32'd8);
    chk("t2_model_left", 32'(exp_q.size()), 32'd0);
    chk("t2_e0", 32'(got_at(0)), 32'h008005);
    chk("t2_e1", 32'(got_at(1)), 32'h00a005);
    chk("t2_e2", 32'(got_at(2)), 32'h008805);
    chk("t2_e3", 32'(got_at(3)), 32'h00a805);
    chk("t2_e4_co1", 32'(got_at(4)), 32'h008015);

    // two pixels on channel_i 0, output-channel-major ordering
    mem[0] = 4'b1001; mem[1] = 4'b0000;
    begin_test();
    start_pulse();
    run_window(60);
    chk("t3_done_cnt", 32'(done_cnt), 32'd1);
    chk("t3_entries", 32'(n_wr), 32'd16);
    chk("t3_model_left", 32'(exp_q.size()), 32'd0);
    chk("t3_e4_pix22", 32'(got_at(4)), 32'h00000a);
    chk("t3_e8_co1", 32'(got_at(8)), 32'h000015);

    // FIFO full stall mid-emit
    begin_test();
    start_pulse();
    wait_wr(3);
    @(posedge clk); #1 full = 1'b1;
    repeat (5) @(posedge clk);
    #1 full = 1'b0;
    run_window(60);
    chk("t4_done_cnt", 32'(done_cnt), 32'd1);
    chk("t4_entries", 32'(n_wr), 32'd16);
    chk("t4_model_left", 32'(exp_q.size()), 32'd0);

    // reset during emit, then a clean rerun
    begin_test();
    start_pulse();
    wait_wr(3);
    rst = 1'b1;
    #1;
    chk("t5_rst_w_en", 32'(w_en), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_word", 32'(valid_pix_pos_o), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    begin_test();
    start_pulse();
    run_window(60);
    chk("t5_done_cnt", 32'(done_cnt), 32'd1);
    chk("t5_entries", 32'(n_wr), 32'd16);
    chk("t5_model_left", 32'(exp_q.size()), 32'd0);
    chk("t5_e0", 32'(got_at(0)), 32'h000005);

    // start while busy is ignored
    mem[0] = 4'b0100; mem[1] = 4'b0010;
    begin_test();
    start_pulse();
    repeat (3) @(posedge clk);
    start_pulse();
    run_window(60);
    chk("t6_done_cnt", 32'(done_cnt), 32'd1);
    chk("t6_entries", 32'(n_wr), 32'd16);
    chk("t6_model_left", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
